// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder. With FULL_ADDER_CARRY_COUNT_EN defined the
// bundle also carries the 16-bit saturating carry_count.
interface full_adder_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             Overflow;
  logic [WIDTH-1:0] Sum_q;
  logic             Carry_q;
  logic             out_valid;
`ifdef FULL_ADDER_CARRY_COUNT_EN
  logic [15:0]      carry_count;
`endif

  modport master (
`ifdef FULL_ADDER_CARRY_COUNT_EN
    input  carry_count,
`endif
    output A,
    output B,
    output Cin,
    output in_valid,
    input  Sum,
    input  Carry,
    input  Overflow,
    input  Sum_q,
    input  Carry_q,
    input  out_valid
  );

  modport slave (
`ifdef FULL_ADDER_CARRY_COUNT_EN
    output carry_count,
`endif
    input  A,
    input  B,
    input  Cin,
    input  in_valid,
    output Sum,
    output Carry,
    output Overflow,
    output Sum_q,
    output Carry_q,
    output out_valid
  );
endinterface

// File: rtl/full_adder.sv
// Ripple-carry adder A + B + Cin with a combinational result and a one-stage registered copy.
// Optional FULL_ADDER_CARRY_COUNT_EN adds a saturating count of valid carry-out cycles.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  full_adder_if.slave  bus
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_cin_vec;
  logic             w_carry;
  logic             w_overflow;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_valid;

  // Carry rippled through a local variable so the chain stays a single comb process.
  always_comb begin
    logic w_c;
    w_sum     = '0;
    w_cin_vec = '0;
    w_c       = bus.Cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_cin_vec[i] = w_c;
      w_sum[i]     = bus.A[i] ^ bus.B[i] ^ w_c;
      w_c          = (bus.A[i] & bus.B[i]) | (w_c & (bus.A[i] ^ bus.B[i]));
    end
    w_carry = w_c;
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign w_overflow = w_carry ^ w_cin_vec[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
      end
    end
  end

  assign bus.Sum       = w_sum;
  assign bus.Carry     = w_carry;
  assign bus.Overflow  = w_overflow;
  assign bus.Sum_q     = r_sum;
  assign bus.Carry_q   = r_carry;
  assign bus.out_valid = r_valid;

`ifdef FULL_ADDER_CARRY_COUNT_EN
  logic [15:0] r_carry_count;
  logic [15:0] w_carry_count_d;

  always_comb begin
    w_carry_count_d = r_carry_count;
    if (bus.in_valid && w_carry && (r_carry_count != 16'hFFFF)) begin
      w_carry_count_d = r_carry_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_count <= 16'd0;
    end else begin
      r_carry_count <= w_carry_count_d;
    end
  end

  assign bus.carry_count = r_carry_count;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder at WIDTH=1 and WIDTH=8.
// The carry-count section is compiled only with FULL_ADDER_CARRY_COUNT_EN defined.
module tb_full_adder;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  full_adder_if #(.WIDTH(1)) u_if1 ();
  full_adder_if #(.WIDTH(8)) u_if8 ();

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if1.slave)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if8.slave)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic vld);
    @(negedge clk);
    u_if8.A        = a;
    u_if8.B        = b;
    u_if8.Cin      = cin;
    u_if8.in_valid = vld;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sum_tab   = 8'b1001_0110;
  logic [7:0] carry_tab = 8'b1110_1000;

  initial begin
    u_if1.A = 1'b0; u_if1.B = 1'b0; u_if1.Cin = 1'b0; u_if1.in_valid = 1'b1;
    u_if8.A = 8'h00; u_if8.B = 8'h00; u_if8.Cin = 1'b0; u_if8.in_valid = 1'b0;

    // Reset held, clock idle: combinational path must still follow the truth table.
    for (int v = 0; v < 8; v++) begin
      u_if1.A   = v[2];
      u_if1.B   = v[1];
      u_if1.Cin = v[0];
      #1;
      check($sformatf("w1_sum_%0d", v), 64'(u_if1.Sum), 64'(sum_tab[v]));
      check($sformatf("w1_carry_%0d", v), 64'(u_if1.Carry), 64'(carry_tab[v]));
      check($sformatf("w1_ovf_%0d", v), 64'(u_if1.Overflow), 64'(carry_tab[v] ^ v[0]));
      check($sformatf("w1_rst_q_%0d", v),
            64'({u_if1.Sum_q, u_if1.Carry_q, u_if1.out_valid}), 64'd0);
      #49;
    end
    check("w8_rst_sum_q", 64'(u_if8.Sum_q), 64'h0);
    check("w8_rst_vld", 64'(u_if8.out_valid), 64'h0);

    u_if1.in_valid = 1'b0;
    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 registered capture of 1+1+1.
    @(negedge clk);
    u_if1.A = 1'b1; u_if1.B = 1'b1; u_if1.Cin = 1'b1; u_if1.in_valid = 1'b1;
    after_edge();
    check("w1_cap_sum_q", 64'(u_if1.Sum_q), 64'h1);
    check("w1_cap_carry_q", 64'(u_if1.Carry_q), 64'h1);
    check("w1_cap_vld", 64'(u_if1.out_valid), 64'h1);
    @(negedge clk);
    u_if1.in_valid = 1'b0;

    // 0xFF + 0x00 + 1 wraps to 0 with carry out.
    drive8(8'hFF, 8'h00, 1'b1, 1'b1);
    check("ff_sum", 64'(u_if8.Sum), 64'h00);
    check("ff_carry", 64'(u_if8.Carry), 64'h1);
    check("ff_ovf", 64'(u_if8.Overflow), 64'h0);
    after_edge();
    check("ff_sum_q", 64'(u_if8.Sum_q), 64'h00);
    check("ff_carry_q", 64'(u_if8.Carry_q), 64'h1);
    check("ff_vld", 64'(u_if8.out_valid), 64'h1);
    drive8(8'h12, 8'h34, 1'b0, 1'b0);
    check("idle_sum", 64'(u_if8.Sum), 64'h46);
    after_edge();
    check("idle_vld", 64'(u_if8.out_valid), 64'h0);
    check("idle_sum_q_hold", 64'(u_if8.Sum_q), 64'h00);
    check("idle_carry_q_hold", 64'(u_if8.Carry_q), 64'h1);

    // Signed overflow cases and a no-overflow wrap.
    drive8(8'h7F, 8'h01, 1'b0, 1'b0);
    check("7f_sum", 64'(u_if8.Sum), 64'h80);
    check("7f_ovf", 64'(u_if8.Overflow), 64'h1);
    check("7f_carry", 64'(u_if8.Carry), 64'h0);
    drive8(8'h80, 8'h80, 1'b0, 1'b0);
    check("80_sum", 64'(u_if8.Sum), 64'h00);
    check("80_carry", 64'(u_if8.Carry), 64'h1);
    check("80_ovf", 64'(u_if8.Overflow), 64'h1);
    drive8(8'h55, 8'hAA, 1'b1, 1'b0);
    check("55_sum", 64'(u_if8.Sum), 64'h00);
    check("55_carry", 64'(u_if8.Carry), 64'h1);
    check("55_ovf", 64'(u_if8.Overflow), 64'h0);

    // Back-to-back valid inputs.
    drive8(8'h03, 8'h04, 1'b0, 1'b1);
    after_edge();
    check("b2b0_sum_q", 64'(u_if8.Sum_q), 64'h07);
    check("b2b0_carry_q", 64'(u_if8.Carry_q), 64'h0);
    drive8(8'hFE, 8'h03, 1'b0, 1'b1);
    after_edge();
    check("b2b1_sum_q", 64'(u_if8.Sum_q), 64'h01);
    check("b2b1_carry_q", 64'(u_if8.Carry_q), 64'h1);
    check("b2b1_vld", 64'(u_if8.out_valid), 64'h1);

    // Reset mid-stream between edges.
    drive8(8'h10, 8'h20, 1'b0, 1'b1);
    after_edge();
    check("mid_sum_q", 64'(u_if8.Sum_q), 64'h30);
    check("mid_vld", 64'(u_if8.out_valid), 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum_q", 64'(u_if8.Sum_q), 64'h00);
    check("mid_rst_vld", 64'(u_if8.out_valid), 64'h0);
    check("mid_rst_comb", 64'(u_if8.Sum), 64'h30);
    rst_n = 1'b1;
    drive8(8'h01, 8'h01, 1'b0, 1'b1);
    after_edge();
    check("post_rst_sum_q", 64'(u_if8.Sum_q), 64'h02);
    check("post_rst_vld", 64'(u_if8.out_valid), 64'h1);
    drive8(8'h00, 8'h00, 1'b0, 1'b0);

`ifdef FULL_ADDER_CARRY_COUNT_EN
    #1;
    rst_n = 1'b0;
    #1;
    check("cnt_rst", 64'(u_if1.carry_count), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    u_if1.A = 1'b1; u_if1.B = 1'b1; u_if1.Cin = 1'b0; u_if1.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) after_edge();
    @(negedge clk);
    u_if1.in_valid = 1'b0;
    check("cnt_five", 64'(u_if1.carry_count), 64'd5);
    after_edge();
    check("cnt_hold_idle", 64'(u_if1.carry_count), 64'd5);
    force u_dut1.r_carry_count = 16'hFFFD;
    #1;
    release u_dut1.r_carry_count;
    @(negedge clk);
    u_if1.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) after_edge();
    check("cnt_sat", 64'(u_if1.carry_count), 64'hFFFF);
    @(negedge clk);
    u_if1.in_valid = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterised ripple-carry full adder: computes A + B + Cin combinationally, with an optional-use pipeline register stage carrying a valid flag.
- Leaf arithmetic block inside datapath adders and ALUs.
- At WIDTH=1 it is the classic 1-bit full adder: Sum and Carry are pure combinational functions of A, B and Cin.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  clock for the registered stage (rising edge).
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry in to bit 0.
- in_valid  input  1  qualifies A/B/Cin for capture into the registered stage.
- Sum  output  WIDTH  combinational sum bits.
- Carry  output  1  combinational carry out of bit WIDTH-1.
- Overflow  output  1  combinational two's-complement signed overflow.
- Sum_q  output  WIDTH  registered Sum.
- Carry_q  output  1  registered Carry.
- out_valid  output  1  registered in_valid.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Combinational path:
  - Per bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = Cin.
  - Sum = {s_WIDTH-1..s_0}; Carry = c_WIDTH; Overflow = c_WIDTH ^ c_WIDTH-1. At WIDTH=1, c_0 is Cin.
  - Result equals (A + B + Cin) mod 2^(WIDTH+1), with bit WIDTH on Carry.
  - Zero latency. Independent of clk, rst_n and in_valid. Valid even while reset is asserted.
- Registered path:
  - rst_n low (asynchronous): Sum_q=0, Carry_q=0, out_valid=0 immediately, held while low.
  - Rising clk with rst_n high and in_valid=1: Sum_q<=Sum, Carry_q<=Carry, out_valid<=1.
  - Rising clk with in_valid=0: Sum_q and Carry_q hold their values; out_valid<=0.
  - Latency: 1 cycle from in_valid to out_valid.
  - Back-to-back valid inputs are accepted every cycle. No stall or backpressure.
  - Reset asserted mid-operation discards the pending result. The first capture after reset release occurs on the first rising edge with rst_n high.
- No internal state other than the registers listed, plus the optional counter below.

Optional Feature:
- Macro: FULL_ADDER_CARRY_COUNT_EN.
- Defined:
  - Adds output carry_count, 16 bits.
  - Counts clock edges where in_valid=1 and Carry=1.
  - Saturates at 0xFFFF and never wraps.
  - Async reset to 0 by rst_n.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=1 exhaustive, 50 ns per vector, A/B/Cin from 000 to 111 -> Sum/Carry = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
- WIDTH=1, rst_n held low, clk idle -> combinational outputs still follow the truth table; Sum_q, Carry_q and out_valid stay at 0.
- WIDTH=8, A=0xFF, B=0x00, Cin=1, in_valid=1 for one cycle:
  - Sum=0x00, Carry=1, Overflow=0 immediately.
  - Next edge: Sum_q=0x00, Carry_q=1, out_valid=1.
  - Following edge with in_valid=0: out_valid=0, Sum_q holds 0x00.
- WIDTH=8 signed overflow:
  - A=0x7F, B=0x01, Cin=0 -> Sum=0x80, Overflow=1, Carry=0.
  - A=0x80, B=0x80 -> Sum=0x00, Carry=1, Overflow=1.
- Reset mid-stream, WIDTH=8:
  - Valid 0x10+0x20 captured, giving Sum_q=0x30.
  - rst_n pulsed low between edges -> Sum_q=0, out_valid=0 asynchronously.
  - After release, next valid input 0x01+0x01 -> Sum_q=0x02 one cycle later.
- With FULL_ADDER_CARRY_COUNT_EN defined, WIDTH=1, A=B=1 with in_valid=1 for 5 cycles -> carry_count=5; preload near saturation (force) and continue -> holds at 0xFFFF.
